// File: rtl/sdram_responder.sv
// sdram_responder
//   Chip-side model of a 16-bit SDR SDRAM. It decodes the command bus driven
//   by the SDRAM controller and keeps per-bank open rows and the mode
//   register. Read bursts are timed by CAS latency and masked writes go to an
//   internal block-RAM array. Protocol violations raise sticky error flags.
//
//   Optional build macro: SDRAM_RESP_TIMING_CHECK_EN
//     When defined, tRCD=2 and tRP=2 are checked per bank (err[1]), and
//     tRC=6 is checked after AUTO_REFRESH (err[2]).
//
//   Ports
//     clk            clock; the command bus is sampled on the rising edge
//     init           synchronous active-high reset (array contents retained)
//     sdram_cke      clock enable; low means the command is ignored
//     sdram_ncs      chip select, active low
//     sdram_nras/ncas/nwe  command strobes
//     sdram_ba       bank address
//     sdram_a        multiplexed row/column/mode address
//     sdram_dqml/h   write byte masks (1 = byte not written)
//     sdram_dq_in    write data from the controller
//     sdram_dq_out   read data
//     sdram_dq_oe    high while sdram_dq_out carries a read word
//     mode_reg       last loaded mode register
//     refresh_cnt    accepted AUTO_REFRESH commands (wraps)
//     err            sticky flags: [0] access to idle bank, [1] ACTIVE on open
//                    bank / tRCD / tRP, [2] refresh or mode load while busy /
//                    tRC, [3] access with unsupported or missing mode
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 9
) (
  input  logic        clk,
  input  logic        init,
  input  logic        sdram_cke,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic [12:0] mode_reg,
  output logic [15:0] refresh_cnt,
  output logic [3:0]  err
);

  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;
  // Longest read: CL=3 plus an 8-word burst, so word 7 is due 10 edges out.
  localparam int SCHED    = 10;

  localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_NOP       = 3'b111;

  // One scheduled read word: which array word to drive, and whether driving
  // it completes an auto-precharge burst on its bank.
  typedef struct packed {
    logic                valid;
    logic                last_pre;
    logic [1:0]          bank;
    logic [IDX_BITS-1:0] idx;
  } slot_t;

  logic [15:0]         mem [DEPTH];
  logic                mode_loaded;
  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [4];
  slot_t               sched   [1:SCHED];
  slot_t               sched_n [1:SCHED];

  // Write burst in progress: wr_k is the index of the next word to write.
  logic                wr_active;
  logic [2:0]          wr_k;
  logic [1:0]          wr_bank;
  logic [ROW_BITS-1:0] wr_row;
  logic [COL_BITS-1:0] wr_col;
  logic [2:0]          wr_mask;
  logic                wr_ilv;
  logic                wr_ap;

  // Sequential bursts wrap inside the BL-aligned block; interleaved bursts
  // XOR the word index into the low column bits.
  function automatic logic [COL_BITS-1:0] burst_col(
    input logic [COL_BITS-1:0] base,
    input logic [2:0]          k,
    input logic [2:0]          mask,
    input logic                ilv
  );
    logic [COL_BITS-1:0] m;
    logic [COL_BITS-1:0] off;
    m   = COL_BITS'(mask);
    off = ilv ? (base ^ COL_BITS'(k)) : (base + COL_BITS'(k));
    return (base & ~m) | (off & m);
  endfunction

  // ---------------------------------------------------------------- decode
  logic [2:0] cmd;
  logic       is_act, is_read, is_write, is_pre, is_ref, is_lmr, is_cmd;
  logic [COL_BITS-1:0] cmd_col;
  logic [ROW_BITS-1:0] cmd_row;

  assign cmd      = (sdram_cke && !sdram_ncs) ? {sdram_nras, sdram_ncas, sdram_nwe} : CMD_NOP;
  assign is_act   = (cmd == CMD_ACTIVE);
  assign is_read  = (cmd == CMD_READ);
  assign is_write = (cmd == CMD_WRITE);
  assign is_pre   = (cmd == CMD_PRECHARGE);
  assign is_ref   = (cmd == CMD_REFRESH);
  assign is_lmr   = (cmd == CMD_LOAD_MODE);
  assign is_cmd   = is_act | is_read | is_write | is_pre | is_ref | is_lmr;
  assign cmd_col  = sdram_a[COL_BITS-1:0];
  assign cmd_row  = bank_row[sdram_ba];

  // Effective burst mask (BL-1) and CAS latency; fall back to BL=1, CL=3
  // when no mode was loaded or the loaded one is unsupported.
  logic       mode_ok;
  logic [2:0] bl_mask;
  logic [1:0] eff_cl;

  always_comb begin
    mode_ok = mode_loaded && (mode_reg[2:0] <= 3'd3) &&
              ((mode_reg[6:4] == 3'd2) || (mode_reg[6:4] == 3'd3));
    bl_mask = 3'd0;
    eff_cl  = 2'd3;
    if (mode_ok) begin
      bl_mask = 3'((4'd1 << mode_reg[1:0]) - 4'd1);
      eff_cl  = mode_reg[5:4];
    end
  end

  // ---------------------------------------------------------- read schedule
  logic rd_fire;
  assign rd_fire = sched[1].valid && !is_write;

  always_comb begin
    for (int i = 1; i < SCHED; i++) sched_n[i] = sched[i+1];
    sched_n[SCHED] = '0;
    if (is_write) begin
      for (int i = 1; i <= SCHED; i++) sched_n[i] = '0;
    end else if (is_read) begin
      // Words already due before the new burst's first word keep going;
      // everything from the new first word onwards is replaced.
      for (int i = 1; i <= SCHED; i++) begin
        if (i >= int'(eff_cl)) begin
          if ((i - int'(eff_cl)) <= int'(bl_mask)) begin
            sched_n[i].valid    = 1'b1;
            sched_n[i].last_pre = sdram_a[10] && ((i - int'(eff_cl)) == int'(bl_mask));
            sched_n[i].bank     = sdram_ba;
            sched_n[i].idx      = {sdram_ba, cmd_row,
                                   burst_col(cmd_col, 3'(i - int'(eff_cl)), bl_mask, mode_reg[3])};
          end else begin
            sched_n[i] = '0;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ write path
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic                wr_cmd_last;   // WRITE command that is also its last word
  logic                wr_burst_last; // continuing burst reaching its last word

  assign wr_cmd_last   = is_write && (mode_reg[9] || (bl_mask == 3'd0));
  assign wr_burst_last = wr_active && !is_write && !is_read && (wr_k == wr_mask);

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (is_write) begin
      wr_en  = 1'b1;
      wr_idx = {sdram_ba, cmd_row, cmd_col};
    end else if (wr_active && !is_read) begin
      wr_en  = 1'b1;
      wr_idx = {wr_bank, wr_row, burst_col(wr_col, wr_k, wr_mask, wr_ilv)};
    end
  end

  always_ff @(posedge clk) begin
    if (!init && wr_en) begin
      if (!sdram_dqml) mem[wr_idx][7:0]  <= sdram_dq_in[7:0];
      if (!sdram_dqmh) mem[wr_idx][15:8] <= sdram_dq_in[15:8];
    end
  end

  // ------------------------------------------------------- bank bookkeeping
  // Auto-precharges that complete at this edge from earlier commands; a
  // command arriving now sees those banks as already idle.
  logic [3:0] ap_prev;
  logic [3:0] open_eff;
  logic [3:0] bank_open_n;
  logic       busy;

  always_comb begin
    ap_prev = 4'b0;
    if (rd_fire && sched[1].last_pre) ap_prev[sched[1].bank] = 1'b1;
    if (wr_burst_last && wr_ap)       ap_prev[wr_bank]       = 1'b1;
    open_eff = bank_open & ~ap_prev;

    bank_open_n = open_eff;
    if (wr_cmd_last && sdram_a[10]) bank_open_n[sdram_ba] = 1'b0;
    if (is_act) bank_open_n[sdram_ba] = 1'b1;
    if (is_pre) begin
      if (sdram_a[10]) bank_open_n = 4'b0;
      else             bank_open_n[sdram_ba] = 1'b0;
    end

    busy = wr_active;
    for (int i = 1; i <= SCHED; i++) busy = busy | sched[i].valid;
  end

  // ---------------------------------------------------------- timing check
  logic tim_rcd_rp;
  logic tim_rc;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  // tRCD and tRP are 2 cycles, so each bank only needs a one-edge blocker;
  // tRC=6 blocks the five edges following AUTO_REFRESH.
  logic [3:0] trcd_busy;
  logic [3:0] trp_busy;
  logic [2:0] trc_cnt;

  always_ff @(posedge clk) begin
    if (init) begin
      trcd_busy <= 4'b0;
      trp_busy  <= 4'b0;
      trc_cnt   <= 3'd0;
    end else begin
      trcd_busy <= 4'b0;
      trp_busy  <= 4'b0;
      if (is_act) trcd_busy[sdram_ba] <= 1'b1;
      if (is_pre) begin
        if (sdram_a[10]) trp_busy <= 4'hF;
        else             trp_busy[sdram_ba] <= 1'b1;
      end
      if (is_ref)                trc_cnt <= 3'd5;
      else if (trc_cnt != 3'd0)  trc_cnt <= trc_cnt - 3'd1;
    end
  end

  assign tim_rcd_rp = ((is_read || is_write) && trcd_busy[sdram_ba]) ||
                      (is_act && trp_busy[sdram_ba]);
  assign tim_rc     = is_cmd && (trc_cnt != 3'd0);
`else
  assign tim_rcd_rp = 1'b0;
  assign tim_rc     = 1'b0;
`endif

  // ---------------------------------------------------------------- errors
  logic [3:0] err_set;
  always_comb begin
    err_set    = 4'b0;
    err_set[0] = (is_read || is_write) && !open_eff[sdram_ba];
    err_set[1] = (is_act && open_eff[sdram_ba]) || tim_rcd_rp;
    err_set[2] = (is_ref && (|open_eff)) || (is_lmr && ((|open_eff) || busy)) || tim_rc;
    err_set[3] = (is_read || is_write) && !mode_ok;
  end

  // ------------------------------------------------------------ state regs
  always_ff @(posedge clk) begin
    if (init) begin
      mode_reg     <= '0;
      mode_loaded  <= 1'b0;
      bank_open    <= 4'b0;
      refresh_cnt  <= '0;
      err          <= '0;
      sdram_dq_oe  <= 1'b0;
      sdram_dq_out <= '0;
      wr_active    <= 1'b0;
      wr_k         <= '0;
      for (int i = 1; i <= SCHED; i++) sched[i] <= '0;
    end else begin
      bank_open   <= bank_open_n;
      err         <= err | err_set;
      sdram_dq_oe <= rd_fire;
      for (int i = 1; i <= SCHED; i++) sched[i] <= sched_n[i];
      if (rd_fire) sdram_dq_out <= mem[sched[1].idx];
      if (is_act) bank_row[sdram_ba] <= sdram_a[ROW_BITS-1:0];
      if (is_ref) refresh_cnt <= refresh_cnt + 16'd1;
      if (is_lmr) begin
        mode_reg    <= sdram_a;
        mode_loaded <= 1'b1;
      end

      if (is_write) begin
        wr_active <= !wr_cmd_last;
        wr_k      <= 3'd1;
        wr_bank   <= sdram_ba;
        wr_row    <= cmd_row;
        wr_col    <= cmd_col;
        wr_mask   <= bl_mask;
        wr_ilv    <= mode_reg[3];
        wr_ap     <= sdram_a[10];
      end else if (is_read || wr_burst_last) begin
        wr_active <= 1'b0;
      end else if (wr_active) begin
        wr_k <= wr_k + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
//   Directed bench for sdram_responder. Commands are driven one per cycle;
//   each READ pushes its expected words and due cycles into a queue, and a
//   monitor on the falling edge pops and compares whenever sdram_dq_oe is
//   high. Register outputs (mode_reg, refresh_cnt, err) are checked inline.
module tb_sdram_responder;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        init;
  logic        cke, ncs, nras, ncas, nwe;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        dqml, dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [12:0] mode_reg;
  logic [15:0] refresh_cnt;
  logic [3:0]  err;

  sdram_responder dut (
    .clk          (clk),
    .init         (init),
    .sdram_cke    (cke),
    .sdram_ncs    (ncs),
    .sdram_nras   (nras),
    .sdram_ncas   (ncas),
    .sdram_nwe    (nwe),
    .sdram_ba     (ba),
    .sdram_a      (a),
    .sdram_dqml   (dqml),
    .sdram_dqmh   (dqmh),
    .sdram_dq_in  (dq_in),
    .sdram_dq_out (dq_out),
    .sdram_dq_oe  (dq_oe),
    .mode_reg     (mode_reg),
    .refresh_cnt  (refresh_cnt),
    .err          (err)
  );

  // ---------------------------------------------------- clock / cycle count
  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ scoreboard
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          checks = 0;
  int          fails  = 0;

  always @(negedge clk) begin
    logic [15:0] ev;
    int          ec;
    if (dq_oe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read_unexpected cyc=%0d got dq=%h oe=1, required oe=0", cyc, dq_out);
      end else begin
        ev = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (dq_out !== ev || cyc != ec) begin
          fails++;
          $display("FAIL read_word got dq=%h at cyc %0d, required dq=%h at cyc %0d",
                   dq_out, cyc, ev, ec);
        end
      end
    end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] < cyc) begin
      checks++;
      fails++;
      ev = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      $display("FAIL read_missing got oe=%b at cyc %0d, required dq=%h at cyc %0d",
               dq_oe, cyc, ev, ec);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, got, want);
    end
  endtask

  task automatic exp_push(input int c, input logic [15:0] v);
    exp_q.push_back(v);
    exp_cyc_q.push_back(c);
  endtask

  // ---------------------------------------------------------- driver tasks
  // Drives one command for one cycle; n returns the edge that samples it.
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d, input logic ml, input logic mh, output int n);
    cke  = 1'b1;
    ncs  = 1'b0;
    {nras, ncas, nwe} = c;
    ba   = b;
    a    = addr;
    dq_in = d;
    dqml = ml;
    dqmh = mh;
    n = cyc + 1;
    @(posedge clk);
    #1;
    ncs  = 1'b1;
    {nras, ncas, nwe} = C_NOP;
    dqml = 1'b0;
    dqmh = 1'b0;
  endtask

  task automatic idle(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) issue(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0, 1'b0, n);
  endtask

  task automatic nop_data(input logic [15:0] d);
    int n;
    issue(C_NOP, 2'd0, 13'd0, d, 1'b0, 1'b0, n);
  endtask

  task automatic cmd_simple(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr);
    int n;
    issue(c, b, addr, 16'd0, 1'b0, 1'b0, n);
  endtask

  task automatic cmd_wr(input logic [1:0] b, input logic [12:0] addr, input logic [15:0] d,
                        input logic ml, input logic mh);
    int n;
    issue(C_WR, b, addr, d, ml, mh, n);
  endtask

  task automatic cmd_rd(input logic [1:0] b, input logic [12:0] addr, output int n);
    issue(C_RD, b, addr, 16'd0, 1'b0, 1'b0, n);
  endtask

  // Precharge all banks, then load a new mode.
  task automatic new_mode(input logic [12:0] m);
    cmd_simple(C_PRE, 2'd0, 13'h400);
    cmd_simple(C_LMR, 2'd0, m);
    idle(1);
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    int n;
    int n2;
    init = 1'b1;
    cke = 1'b1; ncs = 1'b1; {nras, ncas, nwe} = C_NOP;
    ba = 2'd0; a = 13'd0; dqml = 1'b0; dqmh = 1'b0; dq_in = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    init = 1'b0;

    // Reset state
    check("reset_mode_reg", {3'd0, mode_reg}, 16'h0000);
    check("reset_refresh_cnt", refresh_cnt, 16'h0000);
    check("reset_err", {12'd0, err}, 16'h0000);
    check("reset_oe", {15'd0, dq_oe}, 16'h0000);

    // Bring-up
    cmd_simple(C_PRE, 2'd0, 13'h400);
    cmd_simple(C_REF, 2'd0, 13'd0);
    cmd_simple(C_REF, 2'd0, 13'd0);
    cmd_simple(C_LMR, 2'd0, 13'h232);
    idle(2);
    check("bringup_mode_reg", {3'd0, mode_reg}, 16'h0232);
    check("bringup_refresh_cnt", refresh_cnt, 16'd2);
    check("bringup_err", {12'd0, err}, 16'h0000);

    // Mode 0x232: BL=4 sequential, CL=3, single-word writes
    cmd_simple(C_ACT, 2'd1, 13'd3);
    cmd_wr(2'd1, 13'd9,  16'h1111, 1'b0, 1'b0);
    cmd_wr(2'd1, 13'd10, 16'h2222, 1'b0, 1'b0);
    cmd_wr(2'd1, 13'd11, 16'h3333, 1'b0, 1'b0);
    cmd_wr(2'd1, 13'h408, 16'hA5C3, 1'b0, 1'b0);  // auto-precharge
    cmd_simple(C_ACT, 2'd1, 13'd3);
    idle(1);
    cmd_rd(2'd1, 13'd8, n);
    exp_push(n + 3, 16'hA5C3);
    exp_push(n + 4, 16'h1111);
    exp_push(n + 5, 16'h2222);
    exp_push(n + 6, 16'h3333);
    idle(8);
    check("first_read_err", {12'd0, err}, 16'h0000);

    // Byte masks
    cmd_wr(2'd1, 13'd8, 16'h1234, 1'b0, 1'b0);
    cmd_wr(2'd1, 13'd8, 16'hFFFF, 1'b0, 1'b1);
    cmd_wr(2'd1, 13'd9, 16'hABCD, 1'b1, 1'b0);
    cmd_rd(2'd1, 13'd8, n);
    exp_push(n + 3, 16'h12FF);
    exp_push(n + 4, 16'hAB11);
    exp_push(n + 5, 16'h2222);
    exp_push(n + 6, 16'h3333);
    idle(8);

    // Sequential wrap, burst write of cols 4..7 = 0..3
    new_mode(13'h032);
    cmd_simple(C_ACT, 2'd0, 13'd5);
    idle(1);
    cmd_wr(2'd0, 13'd4, 16'd0, 1'b0, 1'b0);
    nop_data(16'd1);
    nop_data(16'd2);
    nop_data(16'd3);
    cmd_rd(2'd0, 13'd6, n);
    exp_push(n + 3, 16'd2);
    exp_push(n + 4, 16'd3);
    exp_push(n + 5, 16'd0);
    exp_push(n + 6, 16'd1);
    idle(8);

    // Interleaved
    new_mode(13'h03A);
    cmd_simple(C_ACT, 2'd0, 13'd5);
    idle(1);
    cmd_rd(2'd0, 13'd6, n);
    exp_push(n + 3, 16'd2);
    exp_push(n + 4, 16'd3);
    exp_push(n + 5, 16'd0);
    exp_push(n + 6, 16'd1);
    idle(8);
    cmd_rd(2'd0, 13'd5, n);
    exp_push(n + 3, 16'd1);
    exp_push(n + 4, 16'd0);
    exp_push(n + 5, 16'd3);
    exp_push(n + 6, 16'd2);
    idle(8);

    // CL=2, BL=2 sequential
    new_mode(13'h021);
    cmd_simple(C_ACT, 2'd0, 13'd5);
    idle(1);
    cmd_rd(2'd0, 13'd5, n);
    exp_push(n + 2, 16'd1);
    exp_push(n + 3, 16'd0);
    idle(6);
    check("modes_err", {12'd0, err}, 16'h0000);

    // Truncation: BL=4, CL=3
    new_mode(13'h032);
    cmd_simple(C_ACT, 2'd0, 13'd5);
    idle(1);
    cmd_wr(2'd0, 13'd0, 16'h0010, 1'b0, 1'b0);
    nop_data(16'h0011);
    nop_data(16'h0012);
    nop_data(16'h0013);
    cmd_wr(2'd0, 13'd16, 16'h0020, 1'b0, 1'b0);
    nop_data(16'h0021);
    nop_data(16'h0022);
    nop_data(16'h0023);
    cmd_rd(2'd0, 13'd0, n);
    idle(1);
    cmd_rd(2'd0, 13'd16, n2);
    exp_push(n + 3, 16'h0010);
    exp_push(n + 4, 16'h0011);
    exp_push(n2 + 3, 16'h0020);
    exp_push(n2 + 4, 16'h0021);
    exp_push(n2 + 5, 16'h0022);
    exp_push(n2 + 6, 16'h0023);
    idle(10);

    // WRITE during read output cuts the burst after one word
    cmd_rd(2'd0, 13'd0, n);
    exp_push(n + 3, 16'h0010);
    idle(3);
    cmd_wr(2'd0, 13'd24, 16'h5555, 1'b0, 1'b0);
    idle(10);
    check("trunc_err", {12'd0, err}, 16'h0000);

    // Errors
    cmd_simple(C_PRE, 2'd0, 13'h400);
    idle(1);
    cmd_rd(2'd0, 13'd0, n);  // idle bank: still served from row 5
    exp_push(n + 3, 16'h0010);
    exp_push(n + 4, 16'h0011);
    exp_push(n + 5, 16'h0012);
    exp_push(n + 6, 16'h0013);
    idle(8);
    check("err_idle_bank", {12'd0, err}, 16'h0001);
    cmd_simple(C_ACT, 2'd0, 13'd5);
    cmd_simple(C_ACT, 2'd0, 13'd5);
    idle(1);
    check("err_double_active", {12'd0, err}, 16'h0003);
    cmd_simple(C_REF, 2'd0, 13'd0);
    idle(1);
    check("err_refresh_open", {12'd0, err}, 16'h0007);
    check("refresh_cnt_3", refresh_cnt, 16'd3);

    // Reset mid-burst: first word out, then init aborts the rest
    cmd_rd(2'd0, 13'd0, n);
    exp_push(n + 3, 16'h0010);
    idle(3);
    init = 1'b1;
    idle(1);
    init = 1'b0;
    check("init_oe", {15'd0, dq_oe}, 16'h0000);
    check("init_err", {12'd0, err}, 16'h0000);
    check("init_mode_reg", {3'd0, mode_reg}, 16'h0000);
    check("init_refresh_cnt", refresh_cnt, 16'h0000);
    idle(6);

    // Access before any LOAD_MODE: err[3], BL=1, CL=3
    cmd_simple(C_ACT, 2'd0, 13'd5);
    idle(1);
    cmd_rd(2'd0, 13'd1, n);
    exp_push(n + 3, 16'h0011);
    idle(8);
    check("err_no_mode", {12'd0, err}, 16'h0008);

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
